norm1_sqsum_window: RTL and testbench

Cross-channel sum-of-squares stage for the norm1 (AlexNet LRN) path. Consumes a per-pixel stream of NUM_CH signed activations and, for each channel c, produces the sum of squares over channels c-HALF..c+HALF, clamped at the channel edges. It sits directly upstream of the signed alpha-scaling multiply, which consumes the 36-bit sum as its signed operand. Each output carries the centre activation so downstream stages can apply the divide.

---
 rtl/norm1_sqsum_window_if.sv | 29 ++
 rtl/norm1_sqsum_window.sv | 151 +++++++++++++++
 tb/tb_norm1_sqsum_window.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/norm1_sqsum_window_if.sv
// Stream bus for the norm1 cross-channel sum-of-squares stage.
// The input side (s_*) carries one signed activation per channel.
// The output side (m_*) carries the windowed sum, the centre activation
// and an end-of-pixel marker.
interface norm1_sqsum_window_if #(
   parameter int DIN_WIDTH = 16,
   parameter int SUM_WIDTH = 36
);
   logic signed [DIN_WIDTH-1:0] s_data;
   logic                        s_valid;
   logic                        s_ready;
   logic        [SUM_WIDTH-1:0] m_sum;
   logic signed [DIN_WIDTH-1:0] m_center;
   logic                        m_last;
   logic                        m_valid;
   logic                        m_ready;

   // The producer drives s_* and consumes m_*.
   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_sum, m_center, m_last, m_valid
   );

   // The windowing stage consumes s_* and produces m_*.
   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_sum, m_center, m_last, m_valid
   );
endinterface

// File: rtl/norm1_sqsum_window.sv
// norm1 (AlexNet LRN) cross-channel sum of squares.
// For every channel c of a pixel, emits the sum of squares over channels
// c-HALF..c+HALF, where neighbours outside the pixel count as zero. Each
// output also carries the centre activation for the downstream divide.
// Optional build macro NORM1_SQSUM_SAT_EN: clamp m_sum to the largest
// positive SUM_WIDTH-bit signed value instead of truncating.
module norm1_sqsum_window #(
   parameter int DIN_WIDTH  = 16,
   parameter int SUM_WIDTH  = 36,
   parameter int LOCAL_SIZE = 5,
   parameter int NUM_CH     = 96
) (
   input logic                  ap_clk,
   input logic                  ap_rst_n,
   norm1_sqsum_window_if.slave  bus
);
   localparam int HALF  = LOCAL_SIZE / 2;
   localparam int SQ_W  = 2 * DIN_WIDTH;
   localparam int ACC_W = SQ_W + $clog2(LOCAL_SIZE);
   localparam int EXT_W = (ACC_W > SUM_WIDTH) ? ACC_W : SUM_WIDTH;
   localparam int CNT_W = $clog2(NUM_CH + HALF);

   // Step indices (0-based) at which each phase of a pixel ends.
   localparam logic [CNT_W-1:0] FILL_END   = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] STREAM_END = CNT_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] DRAIN_END  = CNT_W'(NUM_CH + HALF - 1);

   typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;

   state_t                      state, state_nxt;
   logic [CNT_W-1:0]            ch_cnt, ch_cnt_nxt;
   logic [SQ_W-1:0]             sq_win  [LOCAL_SIZE];
   logic signed [DIN_WIDTH-1:0] din_win [LOCAL_SIZE];
   logic [ACC_W-1:0]            acc, acc_nxt;
   logic                        run_q;
   logic                        adv, step, emit, clear;
   logic signed [SQ_W-1:0]      prod;
   logic [SQ_W-1:0]             sq_in;
   logic signed [DIN_WIDTH-1:0] din_in;
   logic [EXT_W-1:0]            acc_ext;
   logic [SUM_WIDTH-1:0]        sum_out;

   // The pipeline moves only when the output register is free.
   assign adv          = !bus.m_valid || bus.m_ready;
   assign bus.s_ready  = adv && run_q && (state != DRAIN);
   assign step         = (state == DRAIN) ? adv : (bus.s_valid && bus.s_ready);

   // The square is always non-negative, so its bits read as unsigned.
   assign prod   = bus.s_data * bus.s_data;
   assign sq_in  = (state == DRAIN) ? '0 : prod;
   assign din_in = (state == DRAIN) ? '0 : bus.s_data;

   // Running sum: add the entering square, drop the one leaving the window.
   assign acc_nxt = acc + ACC_W'(sq_in) - ACC_W'(sq_win[LOCAL_SIZE-1]);
   assign acc_ext = EXT_W'(acc_nxt);

`ifdef NORM1_SQSUM_SAT_EN
   localparam logic [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (SUM_WIDTH - 1)) - EXT_W'(1);
   assign sum_out = (acc_ext > SAT_MAX) ? SAT_MAX[SUM_WIDTH-1:0] : acc_ext[SUM_WIDTH-1:0];
`else
   assign sum_out = acc_ext[SUM_WIDTH-1:0];
`endif

   // Next-state logic: FILL primes the window, STREAM emits per input,
   // DRAIN flushes the last HALF channels with zero squares.
   always_comb begin
      // NOTE: every output gets a default before the case, so no branch can infer a latch.
      state_nxt  = state;
      ch_cnt_nxt = ch_cnt;
      emit       = 1'b0;
      clear      = 1'b0;
      if (step) begin
         ch_cnt_nxt = ch_cnt + CNT_W'(1);
         unique case (state)
            FILL:   if (ch_cnt == FILL_END) state_nxt = STREAM;
            STREAM: begin
               emit = 1'b1;
               if (ch_cnt == STREAM_END) state_nxt = DRAIN;
            end
            DRAIN:  begin
               emit = 1'b1;
               if (ch_cnt == DRAIN_END) begin
                  clear      = 1'b1;
                  ch_cnt_nxt = '0;
                  state_nxt  = FILL;
               end
            end
            default: state_nxt = FILL;
         endcase
      end
   end

   // State register, channel counter and post-reset input enable.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (!ap_rst_n) begin
         state  <= FILL;
         ch_cnt <= '0;
         run_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ch_cnt <= ch_cnt_nxt;
         run_q  <= 1'b1;
      end
   end

   // Window shift registers and running sum; cleared between pixels.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      // NOTE: the window is reset on purpose: edge channels rely on empty taps reading as zero.
      if (!ap_rst_n) begin
         for (int i = 0; i < LOCAL_SIZE; i++) begin
            sq_win[i]  <= '0;
            din_win[i] <= '0;
         end
         acc <= '0;
      end else if (step) begin
         if (clear) begin
            for (int i = 0; i < LOCAL_SIZE; i++) begin
               sq_win[i]  <= '0;
               din_win[i] <= '0;
            end
            acc <= '0;
         end else begin
            sq_win[0]  <= sq_in;
            din_win[0] <= din_in;
            for (int i = 1; i < LOCAL_SIZE; i++) begin
               sq_win[i]  <= sq_win[i-1];
               din_win[i] <= din_win[i-1];
            end
            acc <= acc_nxt;
         end
      end
   end

   // Output register: loads on each emitting step, holds while stalled.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         bus.m_valid  <= 1'b0;
         bus.m_sum    <= '0;
         bus.m_center <= '0;
         bus.m_last   <= 1'b0;
      end else if (adv) begin
         bus.m_valid <= emit;
         if (emit) begin
            bus.m_sum    <= sum_out;
            bus.m_center <= din_win[HALF-1];
            bus.m_last   <= clear;
         end
      end
   end
endmodule

// File: tb/tb_norm1_sqsum_window.sv
// Bench for norm1_sqsum_window: three instances share one clock/reset.
// dut_a: NUM_CH=8, SUM_WIDTH=36; dut_b: NUM_CH=8, SUM_WIDTH=32 (same stimulus
// as dut_a); dut_c: default NUM_CH=96, SUM_WIDTH=36. Expected sums come from a
// direct windowed sum-of-squares over each pixel's activation list.
`timescale 1ns/1ps
module tb_norm1_sqsum_window;
   localparam int DW       = 16;
   localparam int HALF     = 2;
   localparam int N_SMALL  = 8;
   localparam int N_FULL   = 96;
   localparam int MAX_WAIT = 400;

   typedef longint lq_t[$];
   typedef int     iq_t[$];

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b1;
   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   always @(posedge ap_clk) cycle++;

   norm1_sqsum_window_if #(.DIN_WIDTH(DW), .SUM_WIDTH(36)) if_a ();
   norm1_sqsum_window_if #(.DIN_WIDTH(DW), .SUM_WIDTH(32)) if_b ();
   norm1_sqsum_window_if #(.DIN_WIDTH(DW), .SUM_WIDTH(36)) if_c ();

   logic signed [DW-1:0] s_data  = '0;
   logic                 s_valid = 1'b0;
   logic                 m_ready = 1'b1;
   logic signed [DW-1:0] c_data  = '0;
   logic                 c_valid = 1'b0;

   assign if_a.s_data  = s_data;
   assign if_a.s_valid = s_valid;
   assign if_a.m_ready = m_ready;
   assign if_b.s_data  = s_data;
   assign if_b.s_valid = s_valid;
   assign if_b.m_ready = m_ready;
   assign if_c.s_data  = c_data;
   assign if_c.s_valid = c_valid;
   assign if_c.m_ready = 1'b1;

   norm1_sqsum_window #(.DIN_WIDTH(DW), .SUM_WIDTH(36), .LOCAL_SIZE(5), .NUM_CH(N_SMALL))
      dut_a (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if_a.slave));
   norm1_sqsum_window #(.DIN_WIDTH(DW), .SUM_WIDTH(32), .LOCAL_SIZE(5), .NUM_CH(N_SMALL))
      dut_b (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if_b.slave));
   norm1_sqsum_window #(.DIN_WIDTH(DW), .SUM_WIDTH(36), .LOCAL_SIZE(5), .NUM_CH(N_FULL))
      dut_c (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if_c.slave));

   // Output monitors: record every completed transfer.
   lq_t a_sum, b_sum, c_sum;
   iq_t a_ctr, c_ctr, a_cyc;
   bit  a_last[$], b_last[$], c_last[$];

   always @(negedge ap_clk) begin
      if (if_a.m_valid && if_a.m_ready) begin
         a_sum.push_back(longint'(if_a.m_sum));
         a_ctr.push_back(int'($signed(if_a.m_center)));
         a_last.push_back(if_a.m_last);
         a_cyc.push_back(cycle);
      end
      if (if_b.m_valid && if_b.m_ready) begin
         b_sum.push_back(longint'(if_b.m_sum));
         b_last.push_back(if_b.m_last);
      end
      if (if_c.m_valid && if_c.m_ready) begin
         c_sum.push_back(longint'(if_c.m_sum));
         c_ctr.push_back(int'($signed(if_c.m_center)));
         c_last.push_back(if_c.m_last);
      end
   end

   // Stall monitor: a refused output must stay valid and unchanged.
   logic          a_held = 1'b0;
   logic [35:0]   a_hsum;
   logic [DW-1:0] a_hctr;
   logic          a_hlast;
   always @(negedge ap_clk) begin
      if (a_held && ap_rst_n) begin
         n_checks++;
         if (!if_a.m_valid || if_a.m_sum !== a_hsum || if_a.m_center !== a_hctr || if_a.m_last !== a_hlast) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0b sum=%0d center=%0d last=%0b, expected 1/%0d/%0d/%0b",
                     if_a.m_valid, if_a.m_sum, $signed(if_a.m_center), if_a.m_last, a_hsum, $signed(a_hctr), a_hlast);
         end
      end
      a_held  = if_a.m_valid && !if_a.m_ready && ap_rst_n;
      a_hsum  = if_a.m_sum;
      a_hctr  = if_a.m_center;
      a_hlast = if_a.m_last;
   end

   // Reference: per-channel sum of squares over the clamped window.
   function automatic lq_t model_sums(input iq_t x, input int sw);
      lq_t    r;
      longint s;
      for (int c = 0; c < x.size(); c++) begin
         s = 0;
         for (int j = c - HALF; j <= c + HALF; j++)
            if (j >= 0 && j < x.size()) s += longint'(x[j]) * longint'(x[j]);
`ifdef NORM1_SQSUM_SAT_EN
         if (s > (longint'(1) << (sw - 1)) - 1) s = (longint'(1) << (sw - 1)) - 1;
`else
         s = s & ((longint'(1) << sw) - 1);
`endif
         r.push_back(s);
      end
      return r;
   endfunction

   task automatic clear_q();
      a_sum.delete(); b_sum.delete(); c_sum.delete();
      a_ctr.delete(); c_ctr.delete(); a_cyc.delete();
      a_last.delete(); b_last.delete(); c_last.delete();
   endtask

   // Drives activations into dut_a/dut_b; counts cycles spent refused.
   task automatic drive(input iq_t x, input int max_gap, output int stalls);
      int w;
      stalls = 0;
      foreach (x[i]) begin
         int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin @(posedge ap_clk); #1; end
         end
         s_valid = 1'b1;
         s_data  = DW'(x[i]);
         w = 0;
         @(negedge ap_clk);
         while (!if_a.s_ready && w < MAX_WAIT) begin
            stalls++; w++;
            @(negedge ap_clk);
         end
         if (w >= MAX_WAIT) begin
            n_checks++; n_fail++;
            $display("FAIL drive_timeout: s_ready stayed 0 at input %0d, expected 1", i);
         end
         @(posedge ap_clk); #1;
      end
      s_valid = 1'b0;
   endtask

   // m_ready pattern: 0 = always 1, 1 = toggle 1-0-1-0, 2 = random.
   task automatic ready_pattern(input int mode, input int n);
      int k = 0;
      while (a_sum.size() < n && k < MAX_WAIT) begin
         m_ready = (mode == 1) ? (k % 2 == 0) : (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
         @(posedge ap_clk); #1;
         k++;
      end
      m_ready = 1'b1;
   endtask

   task automatic wait_out(input int n);
      int k = 0;
      while (a_sum.size() < n && k < MAX_WAIT) begin @(posedge ap_clk); #1; k++; end
      repeat (6) begin @(posedge ap_clk); #1; end
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      #12;
      n_checks++;
      if (if_a.m_valid !== 1'b0 || if_a.m_sum !== '0 || if_a.m_center !== '0 || if_a.m_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b sum=%0d center=%0d last=%0b, expected all 0",
                  if_a.m_valid, if_a.m_sum, if_a.m_center, if_a.m_last);
      end
      n_checks++;
      if (if_a.s_ready !== 1'b0 || if_c.s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_s_ready: got a=%0b c=%0b, expected 0", if_a.s_ready, if_c.s_ready);
      end
      n_checks++;
      if (if_b.m_valid !== 1'b0 || if_c.m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid_bc: got b=%0b c=%0b, expected 0", if_b.m_valid, if_c.m_valid);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
   endtask

   task automatic test_basic();
      iq_t x;
      lq_t ea, eb;
      int  st;
      for (int i = 1; i <= N_SMALL; i++) x.push_back(i);
      ea = model_sums(x, 36);
      eb = model_sums(x, 32);
      clear_q();
      drive(x, 0, st);
      wait_out(N_SMALL);
      n_checks++;
      if (a_sum.size() != N_SMALL || b_sum.size() != N_SMALL) begin
         n_fail++;
         $display("FAIL basic_count: got a=%0d b=%0d outputs, expected %0d", a_sum.size(), b_sum.size(), N_SMALL);
      end
      foreach (x[i]) if (i < a_sum.size() && i < b_sum.size()) begin
         n_checks++;
         if (a_sum[i] !== ea[i] || a_ctr[i] !== x[i] || a_last[i] !== (i == N_SMALL - 1) || b_sum[i] !== eb[i]) begin
            n_fail++;
            $display("FAIL basic[%0d]: got sum=%0d center=%0d last=%0b sum32=%0d, expected %0d/%0d/%0b/%0d",
                     i, a_sum[i], a_ctr[i], a_last[i], b_sum[i], ea[i], x[i], i == N_SMALL - 1, eb[i]);
         end
      end
      for (int i = 1; i < a_cyc.size(); i++) begin
         n_checks++;
         if (a_cyc[i] - a_cyc[i-1] != 1) begin
            n_fail++;
            $display("FAIL basic_spacing[%0d]: got gap %0d cycles, expected 1", i, a_cyc[i] - a_cyc[i-1]);
         end
      end
   endtask

   task automatic test_full_scale();
      iq_t xs, xf;
      lq_t ea, eb, ec;
      int  st, w;
      for (int i = 0; i < N_SMALL; i++) xs.push_back(-32768);
      for (int i = 0; i < N_FULL; i++) xf.push_back(-32768);
      ea = model_sums(xs, 36);
      eb = model_sums(xs, 32);
      ec = model_sums(xf, 36);
      clear_q();
      fork
         drive(xs, 0, st);
         begin
            foreach (xf[i]) begin
               c_valid = 1'b1;
               c_data  = DW'(xf[i]);
               w = 0;
               @(negedge ap_clk);
               while (!if_c.s_ready && w < MAX_WAIT) begin w++; @(negedge ap_clk); end
               @(posedge ap_clk); #1;
            end
            c_valid = 1'b0;
         end
      join
      wait_out(N_SMALL);
      n_checks++;
      if (c_sum.size() != N_FULL || a_sum.size() != N_SMALL || b_sum.size() != N_SMALL) begin
         n_fail++;
         $display("FAIL full_count: got c=%0d a=%0d b=%0d, expected %0d/%0d/%0d",
                  c_sum.size(), a_sum.size(), b_sum.size(), N_FULL, N_SMALL, N_SMALL);
      end
      foreach (xf[i]) if (i < c_sum.size()) begin
         n_checks++;
         if (c_sum[i] !== ec[i] || c_ctr[i] !== -32768 || c_last[i] !== (i == N_FULL - 1)) begin
            n_fail++;
            $display("FAIL full96[%0d]: got sum=%0d center=%0d last=%0b, expected %0d/-32768/%0b",
                     i, c_sum[i], c_ctr[i], c_last[i], ec[i], i == N_FULL - 1);
         end
      end
      foreach (xs[i]) if (i < a_sum.size() && i < b_sum.size()) begin
         n_checks++;
         if (a_sum[i] !== ea[i] || b_sum[i] !== eb[i] || b_last[i] !== (i == N_SMALL - 1)) begin
            n_fail++;
            $display("FAIL full8[%0d]: got sum36=%0d sum32=%0d last32=%0b, expected %0d/%0d/%0b",
                     i, a_sum[i], b_sum[i], b_last[i], ea[i], eb[i], i == N_SMALL - 1);
         end
      end
   endtask

   task automatic test_backpressure(input int mode, input int n_pix);
      iq_t x;
      lq_t ea, eb, tmp;
      int  st;
      for (int p = 0; p < n_pix; p++) begin
         iq_t px;
         for (int i = 1; i <= N_SMALL; i++)
            px.push_back((mode == 2) ? int'($urandom_range(65535)) - 32768 : i);
         tmp = model_sums(px, 36);
         foreach (tmp[i]) ea.push_back(tmp[i]);
         tmp = model_sums(px, 32);
         foreach (tmp[i]) eb.push_back(tmp[i]);
         foreach (px[i]) x.push_back(px[i]);
      end
      clear_q();
      fork
         drive(x, 2, st);
         ready_pattern(mode, x.size());
      join
      wait_out(x.size());
      n_checks++;
      if (a_sum.size() != x.size() || b_sum.size() != x.size()) begin
         n_fail++;
         $display("FAIL stall_count_m%0d: got a=%0d b=%0d outputs, expected %0d", mode, a_sum.size(), b_sum.size(), x.size());
      end
      foreach (x[i]) if (i < a_sum.size() && i < b_sum.size()) begin
         n_checks++;
         if (a_sum[i] !== ea[i] || a_ctr[i] !== x[i] || a_last[i] !== (i % N_SMALL == N_SMALL - 1) || b_sum[i] !== eb[i]) begin
            n_fail++;
            $display("FAIL stall_m%0d[%0d]: got sum=%0d center=%0d last=%0b sum32=%0d, expected %0d/%0d/%0b/%0d",
                     mode, i, a_sum[i], a_ctr[i], a_last[i], b_sum[i], ea[i], x[i], i % N_SMALL == N_SMALL - 1, eb[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      iq_t x;
      lq_t ea;
      int  st;
      for (int i = 1; i <= N_SMALL; i++) x.push_back(i);
      for (int i = 0; i < N_SMALL; i++) x.push_back(2);
      ea = {12, 16, 20, 20, 20, 20, 16, 12};
      clear_q();
      drive(x, 0, st);
      wait_out(2 * N_SMALL);
      n_checks++;
      if (st != HALF) begin
         n_fail++;
         $display("FAIL b2b_gap: got s_ready low for %0d cycles, expected %0d", st, HALF);
      end
      n_checks++;
      if (a_sum.size() != 2 * N_SMALL) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d outputs, expected %0d", a_sum.size(), 2 * N_SMALL);
      end
      for (int i = 0; i < N_SMALL; i++) if (N_SMALL + i < a_sum.size()) begin
         n_checks++;
         if (a_sum[N_SMALL+i] !== ea[i] || a_ctr[N_SMALL+i] !== 2 || a_last[N_SMALL+i] !== (i == N_SMALL - 1)) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got sum=%0d center=%0d last=%0b, expected %0d/2/%0b",
                     i, a_sum[N_SMALL+i], a_ctr[N_SMALL+i], a_last[N_SMALL+i], ea[i], i == N_SMALL - 1);
         end
      end
      for (int i = 1; i < N_SMALL && i < a_cyc.size(); i++) begin
         n_checks++;
         if (a_cyc[N_SMALL+i-1] - a_cyc[N_SMALL+i-2] != 1 && i > 1) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: got gap %0d, expected 1", i, a_cyc[N_SMALL+i-1] - a_cyc[N_SMALL+i-2]);
         end
      end
   endtask

   task automatic test_reset_midpixel();
      iq_t x5, x;
      lq_t ea;
      int  st;
      for (int i = 1; i <= 5; i++) x5.push_back(i);
      for (int i = 1; i <= N_SMALL; i++) x.push_back(i);
      ea = model_sums(x, 36);
      clear_q();
      drive(x5, 0, st);
      n_checks++;
      if (if_a.m_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre: got m_valid=%0b before reset, expected 1", if_a.m_valid);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      n_checks++;
      if (if_a.m_valid !== 1'b0 || if_a.m_sum !== '0 || if_a.m_center !== '0 || if_a.m_last !== 1'b0 || if_a.s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async: got valid=%0b sum=%0d center=%0d last=%0b ready=%0b, expected all 0",
                  if_a.m_valid, if_a.m_sum, if_a.m_center, if_a.m_last, if_a.s_ready);
      end
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      clear_q();
      repeat (4) begin @(posedge ap_clk); #1; end
      n_checks++;
      if (a_sum.size() != 0) begin
         n_fail++;
         $display("FAIL midreset_abort: got %0d outputs after reset, expected 0", a_sum.size());
      end
      drive(x, 0, st);
      wait_out(N_SMALL);
      n_checks++;
      if (a_sum.size() != N_SMALL) begin
         n_fail++;
         $display("FAIL midreset_count: got %0d outputs, expected %0d", a_sum.size(), N_SMALL);
      end
      foreach (x[i]) if (i < a_sum.size()) begin
         n_checks++;
         if (a_sum[i] !== ea[i] || a_ctr[i] !== x[i] || a_last[i] !== (i == N_SMALL - 1)) begin
            n_fail++;
            $display("FAIL midreset[%0d]: got sum=%0d center=%0d last=%0b, expected %0d/%0d/%0b",
                     i, a_sum[i], a_ctr[i], a_last[i], ea[i], x[i], i == N_SMALL - 1);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_full_scale();
      test_backpressure(1, 1);
      test_back_to_back();
      test_reset_midpixel();
      test_backpressure(2, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
